// File: rtl/clk_pkg.sv
// Clock-domain constants shared by the front-panel logic.
// Converts human time units into cycle counts for parameter defaults.
package clk_pkg;

    localparam int CLK_HZ = 100000000;

    // Milliseconds to clock cycles at CLK_HZ. Uses 64-bit math so long delays do not overflow.
    function automatic int ms_to_cycles(input int ms);
        return int'((longint'(CLK_HZ) * longint'(ms)) / 64'sd1000);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One push-button channel: 2-flop synchroniser, stability-count debouncer,
// registered press/release pulses and a press-and-hold auto-repeat FSM.
module btn_debounce_ch #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 20000000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    localparam int CW   = $clog2(STABLE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    // Terminal counts. With REPEAT_DELAY == 0 the DELAY state is unreachable,
    // so the wrapped value of DLY_LAST is never used.
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          pressed;
    logic          accept;
    logic          lvl_nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rcnt;
    rpt_state_t    state;

    // Normalised so that 1 always means "pressed", whatever the pin polarity.
    assign pressed = sync_p1 ^ ACTIVE_LOW;
    // The input has disagreed with the debounced level for STABLE_CYCLES edges.
    assign accept  = (pressed != o_level) && (cnt == CNT_LAST);
    // Level that o_level takes at this edge; the repeat FSM follows it so that
    // it reacts in the same cycle as the press/release pulse.
    assign lvl_nxt = accept ? pressed : o_level;

    // Two-flop synchroniser, parked at the released pin level in reset so
    // that leaving reset never looks like a transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_p0 <= ACTIVE_LOW;
            sync_p1 <= ACTIVE_LOW;
        end else begin
            sync_p0 <= i_btn;
            sync_p1 <= sync_p0;
        end
    end

    // Stability counter; any cycle that agrees with o_level restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= accept && pressed;
            o_release <= accept && !pressed;
            if (pressed == o_level) begin
                cnt <= '0;
            end else if (accept) begin
                o_level <= pressed;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Auto-repeat: a release (including the release cycle itself) forces IDLE
    // and overrides any repeat pulse that would coincide with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            rcnt     <= '0;
            o_repeat <= 1'b0;
        end else if (!lvl_nxt) begin
            state    <= ST_IDLE;
            rcnt     <= '0;
            o_repeat <= 1'b0;
        end else begin
            o_repeat <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!o_level && (REPEAT_DELAY > 0)) begin
                        state <= ST_DELAY;
                        rcnt  <= '0;
                    end
                end
                ST_DELAY: begin
                    if (rcnt == DLY_LAST) begin
                        o_repeat <= 1'b1;
                        rcnt     <= '0;
                        state    <= ST_REPEAT;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (rcnt == PER_LAST) begin
                        o_repeat <= 1'b1;
                        rcnt     <= '0;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    rcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Front-panel button conditioner: NUM_BTN independent debounce channels
// producing clean levels, press/release pulses and auto-repeat pulses for
// the time-setting logic.
module btn_debounce
    import clk_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int STABLE_CYCLES = ms_to_cycles(10),
    parameter int REPEAT_DELAY  = ms_to_cycles(500),
    parameter int REPEAT_PERIOD = ms_to_cycles(200),
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_repeat
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_btn     (i_btn[g]),
            .o_level   (o_level[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_repeat  (o_repeat[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: expected pulse events are queued with their due
// cycle when stimulus is driven, then matched against the outputs every cycle.
module tb_btn_debounce;

    localparam int NB  = 2;
    localparam int SC  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = SC + 2;   // drive cycle to pulse cycle

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic [NB-1:0] o_level, o_press, o_release, o_repeat;

    btn_debounce #(
        .NUM_BTN       (NB),
        .STABLE_CYCLES (SC),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_btn     (btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_repeat  (o_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 press, 1 release, 2 repeat
    } ev_t;

    ev_t           sb[$];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    logic [NB-1:0] exp_level = '0;
    int            p_cyc[NB];
    string         kname[3] = '{"press", "release", "repeat"};
    logic          m_obs, m_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the press and a long train of repeats; release prunes the tail.
    task automatic arm_press(input int ch);
        ev_t e;
        p_cyc[ch] = cyc + LAT;
        e.cyc = p_cyc[ch]; e.ch = ch; e.kind = 0;
        sb.push_back(e);
        for (int k = 0; k < 40; k++) begin
            e.cyc = p_cyc[ch] + RD + k * RP; e.kind = 2;
            sb.push_back(e);
        end
    endtask

    task automatic press(input int ch);
        btn[ch] = 1'b0;
        arm_press(ch);
    endtask

    task automatic release_btn(input int ch);
        ev_t e;
        int  rel;
        btn[ch] = 1'b1;
        rel = cyc + LAT;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].ch == ch && sb[i].kind == 2 && sb[i].cyc >= rel)
                sb.delete(i);
        e.cyc = rel; e.ch = ch; e.kind = 1;
        sb.push_back(e);
    endtask

    // Per-cycle scoreboard: every output bit is compared, so both missing and
    // spurious pulses are caught.
    always @(negedge clk) begin
        for (int ch = 0; ch < NB; ch++) begin
            for (int k = 0; k < 3; k++) begin
                m_obs = (k == 0) ? o_press[ch] : (k == 1) ? o_release[ch] : o_repeat[ch];
                m_exp = 1'b0;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].cyc == cyc && sb[i].ch == ch && sb[i].kind == k) begin
                        m_exp = 1'b1;
                        sb.delete(i);
                        break;
                    end
                end
                if (m_exp && k == 0) exp_level[ch] = 1'b1;
                if (m_exp && k == 1) exp_level[ch] = 1'b0;
                check($sformatf("%s%0d", kname[k], ch), 32'(m_obs), 32'(m_exp));
            end
            check($sformatf("level%0d", ch), 32'(o_level[ch]), 32'(exp_level[ch]));
        end
    end

    initial begin
        rst_n = 1'b0;
        btn   = 2'b11;
        tick(3);
        rst_n = 1'b1;
        tick(20);

        // Clean press, long hold with repeats, then release
        press(0);
        tick(30);
        release_btn(0);
        tick(15);

        // Three-cycle glitch must be rejected
        btn[0] = 1'b0;
        tick(3);
        btn[0] = 1'b1;
        tick(15);

        // Bounce 0,1,0,1 then steady 0; release lands on a repeat cycle
        btn[0] = 1'b0; tick(1);
        btn[0] = 1'b1; tick(1);
        btn[0] = 1'b0; tick(1);
        btn[0] = 1'b1; tick(1);
        press(0);
        tick(16);
        release_btn(0);
        tick(15);

        // Independent channels, button 1 three cycles after button 0
        press(0);
        tick(3);
        press(1);
        tick(12);
        release_btn(0);
        tick(12);
        release_btn(1);
        tick(15);

        // Reset while in the repeat phase with the button held
        press(0);
        tick(25);
        rst_n = 1'b0;
        sb.delete();
        exp_level = '0;
        #1;
        check("rst_async_level", 32'(o_level), 32'd0);
        check("rst_async_repeat", 32'(o_repeat), 32'd0);
        tick(3);
        rst_n = 1'b1;
        arm_press(0);
        tick(20);
        release_btn(0);
        tick(15);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
